// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the MIPS data-memory controller: FSM state
// encodings, access-size codes and small lane helpers.
package data_mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DUMP_RD   = 3'd1,
        ST_DUMP_WAIT = 3'd2,
        ST_DUMP_DONE = 3'd3,
        ST_RMW_WR    = 3'd4
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    // Byte and half stores need a read-modify-write; both word codes do not.
    function automatic logic is_sub_word(input logic [1:0] size);
        return (size == SIZE_BYTE) || (size == SIZE_HALF);
    endfunction

    // Left shift that places a right-justified lane at its big-endian position.
    function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] off);
        logic [4:0] sh;
        case (size)
            SIZE_BYTE: sh = {~off, 3'b000};          // byte 0 -> bits 31:24
            SIZE_HALF: sh = {~off[1], 4'b0000};      // half 0 -> bits 31:16
            default:   sh = 5'd0;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_store_merge.sv
// Combinational lane merge for sub-word stores: replaces the selected
// big-endian byte/half of the old RAM word with the right-justified store data.
module data_mem_ctrl_store_merge
    import data_mem_ctrl_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    output logic [31:0] merged
);

    logic [4:0]  shift_s;
    logic [31:0] mask_s;

    // Build the lane mask at the target position and splice the new data in.
    always_comb begin
        shift_s = lane_shift(size, off);
        case (size)
            SIZE_BYTE: mask_s = 32'h0000_00FF << shift_s;
            SIZE_HALF: mask_s = 32'h0000_FFFF << shift_s;
            default:   mask_s = 32'hFFFF_FFFF;
        endcase
        merged = (old_word & ~mask_s) | ((wdata << shift_s) & mask_s);
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-RAM sequencer: serves MEM-stage loads/stores (sub-word stores via
// read-modify-write) and streams a full-memory dump to the debug unit.
// The CPU always wins the single RAM port; the dump pauses around it.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int RAM_DEPTH  = 1024,
    parameter int RAM_ADDR_W = 10,
    parameter int CPU_ADDR_W = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_re,
    input  logic                  cpu_we,
    input  logic [1:0]            cpu_size,
    input  logic [CPU_ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  dbg_start,
    output logic                  dbg_valid,
    input  logic                  dbg_ready,
    output logic [DATA_W-1:0]     dbg_data,
    output logic [RAM_ADDR_W-1:0] dbg_addr,
    output logic                  dbg_done,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0]     ram_din,
    output logic                  ram_we,
    output logic                  ram_en,
    input  logic [DATA_W-1:0]     ram_dout
);

    localparam logic [RAM_ADDR_W-1:0] CNT_LAST = RAM_ADDR_W'(RAM_DEPTH - 1);
    localparam logic [RAM_ADDR_W-1:0] CNT_ONE  = RAM_ADDR_W'(1);

    state_t                  state_r, next_state_s;
    state_t                  ret_r, ret_next_s;
    state_t                  dump_next_s;
    logic [RAM_ADDR_W-1:0]   cnt_r, cnt_next_s;
    logic [DATA_W-1:0]       dbg_data_r;
    logic [RAM_ADDR_W-1:0]   dbg_addr_r;
    logic [DATA_W-1:0]       old_word_r;
    logic [DATA_W-1:0]       rmw_wdata_r;
    logic [RAM_ADDR_W-1:0]   rmw_addr_r;
    logic [1:0]              rmw_size_r;
    logic [1:0]              rmw_off_r;
    logic [DATA_W-1:0]       merged_s;
    logic                    cpu_acc_s;
    logic [RAM_ADDR_W-1:0]   cpu_word_addr_s;
    logic                    capture_s;
    logic                    rmw_start_s;
    logic                    ram_en_s;
    logic                    ram_we_s;
    logic                    cpu_stall_s;
    logic [RAM_ADDR_W-1:0]   ram_addr_s;
    logic [DATA_W-1:0]       ram_din_s;

    assign cpu_acc_s       = cpu_re | cpu_we;
    assign cpu_word_addr_s = cpu_addr[CPU_ADDR_W-1:2];

    data_mem_ctrl_store_merge u_store_merge (
        .old_word (old_word_r),
        .wdata    (rmw_wdata_r),
        .size     (rmw_size_r),
        .off      (rmw_off_r),
        .merged   (merged_s)
    );

    // Dump-side next state: where the dump would go this cycle, ignoring any RMW detour.
    always_comb begin
        dump_next_s = state_r;
        cnt_next_s  = cnt_r;
        capture_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (dbg_start && !cpu_acc_s) begin
                    dump_next_s = ST_DUMP_RD;
                    cnt_next_s  = '0;
                end else begin
                    dump_next_s = ST_IDLE;
                end
            end
            ST_DUMP_RD: begin
                if (!cpu_acc_s) begin
                    capture_s   = 1'b1;
                    dump_next_s = ST_DUMP_WAIT;
                end else begin
                    dump_next_s = ST_DUMP_RD;
                end
            end
            ST_DUMP_WAIT: begin
                if (dbg_ready) begin
                    if (cnt_r == CNT_LAST) begin
                        dump_next_s = ST_DUMP_DONE;
                    end else begin
                        cnt_next_s  = cnt_r + CNT_ONE;
                        dump_next_s = ST_DUMP_RD;
                    end
                end else begin
                    dump_next_s = ST_DUMP_WAIT;
                end
            end
            ST_DUMP_DONE: begin
                dump_next_s = ST_IDLE;
            end
            ST_RMW_WR: begin
                // dbg_valid stays up while the write detours, so a handshake still counts.
                if ((ret_r == ST_DUMP_WAIT) && dbg_ready) begin
                    if (cnt_r == CNT_LAST) begin
                        dump_next_s = ST_DUMP_DONE;
                    end else begin
                        cnt_next_s  = cnt_r + CNT_ONE;
                        dump_next_s = ST_DUMP_RD;
                    end
                end else begin
                    dump_next_s = ret_r;
                end
            end
            default: begin
                dump_next_s = ST_IDLE;
            end
        endcase
    end

    // RAM port arbitration: RMW write, then CPU access, then dump read.
    always_comb begin
        next_state_s = dump_next_s;
        ret_next_s   = ret_r;
        rmw_start_s  = 1'b0;
        ram_en_s     = 1'b0;
        ram_we_s     = 1'b0;
        ram_addr_s   = cpu_word_addr_s;
        ram_din_s    = cpu_wdata;
        cpu_stall_s  = 1'b0;
        if (state_r == ST_RMW_WR) begin
            ram_en_s   = 1'b1;
            ram_we_s   = 1'b1;
            ram_addr_s = rmw_addr_r;
            ram_din_s  = merged_s;
        end else if (cpu_acc_s) begin
            ram_en_s = 1'b1;
            if (cpu_we && is_sub_word(cpu_size)) begin
                cpu_stall_s  = 1'b1;
                rmw_start_s  = 1'b1;
                ret_next_s   = dump_next_s;
                next_state_s = ST_RMW_WR;
            end else if (cpu_we) begin
                ram_we_s = 1'b1;
            end else begin
                ram_we_s = 1'b0;
            end
        end else if (state_r == ST_DUMP_RD) begin
            ram_en_s   = 1'b1;
            ram_addr_s = cnt_r;
        end else begin
            ram_en_s = 1'b0;
        end
    end

    // FSM, return-state, dump counter and captured dump word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            ret_r      <= ST_IDLE;
            cnt_r      <= '0;
            dbg_data_r <= '0;
            dbg_addr_r <= '0;
        end else begin
            state_r <= next_state_s;
            ret_r   <= ret_next_s;
            cnt_r   <= cnt_next_s;
            if (capture_s) begin
                dbg_data_r <= ram_dout;
                dbg_addr_r <= cnt_r;
            end
        end
    end

    // Snapshot of the old word and store request for the RMW write cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            old_word_r  <= '0;
            rmw_wdata_r <= '0;
            rmw_addr_r  <= '0;
            rmw_size_r  <= SIZE_WORD;
            rmw_off_r   <= 2'b00;
        end else if (rmw_start_s) begin
            old_word_r  <= ram_dout;
            rmw_wdata_r <= cpu_wdata;
            rmw_addr_r  <= cpu_word_addr_s;
            rmw_size_r  <= cpu_size;
            rmw_off_r   <= cpu_addr[1:0];
        end
    end

    // Reset gates the strobes so an in-flight merged write is dropped.
    assign ram_en    = ram_en_s & ~reset;
    assign ram_we    = ram_we_s & ~reset;
    assign cpu_stall = cpu_stall_s & ~reset;
    assign ram_addr  = ram_addr_s;
    assign ram_din   = ram_din_s;
    assign cpu_rdata = ram_dout;
    assign dbg_valid = (state_r == ST_DUMP_WAIT) ||
                       ((state_r == ST_RMW_WR) && (ret_r == ST_DUMP_WAIT));
    assign dbg_done  = (state_r == ST_DUMP_DONE);
    assign dbg_data  = dbg_data_r;
    assign dbg_addr  = dbg_addr_r;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a 16-word negedge RAM model
// (word i initialised to i+128).
module tb_data_mem_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CAW   = 6;

    logic           clk;
    logic           reset;
    logic           cpu_re, cpu_we;
    logic [1:0]     cpu_size;
    logic [CAW-1:0] cpu_addr;
    logic [DW-1:0]  cpu_wdata, cpu_rdata;
    logic           cpu_stall;
    logic           dbg_start, dbg_valid, dbg_ready, dbg_done;
    logic [DW-1:0]  dbg_data;
    logic [AW-1:0]  dbg_addr;
    logic [AW-1:0]  ram_addr;
    logic [DW-1:0]  ram_din, ram_dout;
    logic           ram_we, ram_en;

    logic [DW-1:0]  mem     [DEPTH];
    logic [DW-1:0]  exp_mem [DEPTH];
    int checks;
    int errors;

    data_mem_ctrl #(.DATA_W(DW), .RAM_DEPTH(DEPTH), .RAM_ADDR_W(AW), .CPU_ADDR_W(CAW)) dut (
        .clk(clk), .reset(reset),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_start(dbg_start), .dbg_valid(dbg_valid), .dbg_ready(dbg_ready),
        .dbg_data(dbg_data), .dbg_addr(dbg_addr), .dbg_done(dbg_done),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_en(ram_en),
        .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first single-port RAM acting on the falling edge.
    always @(negedge clk) begin
        logic [DW-1:0] rd;
        if (ram_en) begin
            rd = mem[ram_addr];
            if (ram_we) mem[ram_addr] = ram_din;
            ram_dout = rd;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time expired");
        $fatal(1);
    end

    task automatic to_check();
        @(negedge clk); #1;
    endtask

    task automatic to_drive();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        cpu_re = 1'b0; cpu_we = 1'b0; cpu_size = 2'b11;
        cpu_addr = '0; cpu_wdata = '0; dbg_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle_inputs(); dbg_ready = 1'b0;
        to_drive(); to_drive();
        reset = 1'b0;
        to_check();
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", cpu_stall); end
        checks++; if (dbg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", dbg_valid); end
        checks++; if (dbg_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", dbg_done); end
        checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL reset_dbg_data got %h exp 0", dbg_data); end
        checks++; if (dbg_addr !== 4'h0) begin errors++; $display("FAIL reset_dbg_addr got %h exp 0", dbg_addr); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got %b exp 0", ram_we); end
        checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL reset_ram_en got %b exp 0", ram_en); end
        to_drive();
    endtask

    task automatic test_load();
        cpu_re = 1'b1; cpu_size = 2'b11; cpu_addr = 6'h08;
        to_check();
        checks++; if (cpu_rdata !== 32'h0000_0082) begin errors++; $display("FAIL load_data got %h exp 00000082", cpu_rdata); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL load_stall got %b exp 0", cpu_stall); end
        checks++; if (ram_en !== 1'b1) begin errors++; $display("FAIL load_ram_en got %b exp 1", ram_en); end
        to_drive();
        idle_inputs();
    endtask

    // Runs one dump; ready low on cycles [rdy_lo, rdy_hi); optional LW/SB injected.
    task automatic run_dump(input string tag, input int rdy_lo, input int rdy_hi, input bit inject);
        int idx = 0;
        int done_cnt = 0;
        bit done_seen = 1'b0;
        bit prev_valid = 1'b0;
        bit prev_ready = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic [AW-1:0] prev_addr = '0;
        for (int c = 0; c < 300; c++) begin
            idle_inputs();
            dbg_start = (c == 0);
            dbg_ready = !(c >= rdy_lo && c < rdy_hi);
            if (inject && c == 5) begin
                cpu_re = 1'b1; cpu_size = 2'b11; cpu_addr = 6'h08;
            end else if (inject && (c == 10 || c == 11)) begin
                cpu_we = 1'b1; cpu_size = 2'b00; cpu_addr = 6'h3C; cpu_wdata = 32'h0000_0077;
            end
            to_check();
            if (inject && c == 5) begin
                checks++; if (cpu_rdata !== exp_mem[2]) begin errors++; $display("FAIL %s mid_load got %h exp %h", tag, cpu_rdata, exp_mem[2]); end
                checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL %s mid_load_stall got %b exp 0", tag, cpu_stall); end
            end
            if (inject && c == 10) begin
                checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL %s mid_sb_stall1 got %b exp 1", tag, cpu_stall); end
            end
            if (inject && c == 11) begin
                checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL %s mid_sb_stall2 got %b exp 0", tag, cpu_stall); end
            end
            if (prev_valid && !prev_ready) begin
                checks++;
                if (dbg_valid !== 1'b1 || dbg_data !== prev_data || dbg_addr !== prev_addr) begin
                    errors++;
                    $display("FAIL %s hold got v=%b %h@%0d exp v=1 %h@%0d", tag, dbg_valid, dbg_data, dbg_addr, prev_data, prev_addr);
                end
            end
            if (dbg_valid && dbg_ready) begin
                checks++;
                if (idx >= DEPTH) begin
                    errors++; $display("FAIL %s extra_word got addr %0d exp none", tag, dbg_addr);
                end else if (dbg_addr !== AW'(idx) || dbg_data !== exp_mem[idx]) begin
                    errors++;
                    $display("FAIL %s word got %h@%0d exp %h@%0d", tag, dbg_data, dbg_addr, exp_mem[idx], idx);
                end
                idx++;
            end
            if (dbg_done) begin
                done_cnt++;
                if (!done_seen) begin
                    checks++; if (idx !== DEPTH) begin errors++; $display("FAIL %s done_early got words %0d exp %0d", tag, idx, DEPTH); end
                end
                done_seen = 1'b1;
            end
            prev_valid = dbg_valid; prev_ready = dbg_ready;
            prev_data = dbg_data;   prev_addr = dbg_addr;
            to_drive();
            if (done_seen) break;
        end
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            to_check();
            if (dbg_done) done_cnt++;
            to_drive();
        end
        checks++; if (!done_seen) begin errors++; $display("FAIL %s timeout got no dbg_done exp pulse", tag); end
        checks++; if (idx !== DEPTH) begin errors++; $display("FAIL %s word_count got %0d exp %0d", tag, idx, DEPTH); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL %s done_pulses got %0d exp 1", tag, done_cnt); end
    endtask

    task automatic test_dump_basic();
        run_dump("dump_basic", 1000, 1000, 1'b0);
    endtask

    task automatic test_word_store();
        cpu_we = 1'b1; cpu_size = 2'b11; cpu_addr = 6'h10; cpu_wdata = 32'hDEAD_BEEF;
        to_check();
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL sw_stall got %b exp 0", cpu_stall); end
        checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL sw_ram_we got %b exp 1", ram_we); end
        to_drive();
        cpu_we = 1'b0; cpu_re = 1'b1;
        to_check();
        checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_readback got %h exp deadbeef", cpu_rdata); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL sw_lw_stall got %b exp 0", cpu_stall); end
        to_drive();
        idle_inputs();
        exp_mem[4] = 32'hDEAD_BEEF;
    endtask

    // Sub-word store: stall on the read cycle, write on the second, then read back.
    task automatic sub_store(input string tag, input logic [1:0] size, input logic [5:0] addr,
                             input logic [31:0] wdata, input logic [31:0] expw);
        cpu_we = 1'b1; cpu_size = size; cpu_addr = addr; cpu_wdata = wdata;
        to_check();
        checks++; if (cpu_stall !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL %s rd_cycle got stall=%b we=%b exp stall=1 we=0", tag, cpu_stall, ram_we); end
        to_drive();
        to_check();
        checks++; if (cpu_stall !== 1'b0 || ram_we !== 1'b1) begin errors++; $display("FAIL %s wr_cycle got stall=%b we=%b exp stall=0 we=1", tag, cpu_stall, ram_we); end
        to_drive();
        cpu_we = 1'b0; cpu_re = 1'b1; cpu_size = 2'b11; cpu_addr = {addr[5:2], 2'b00};
        to_check();
        checks++; if (cpu_rdata !== expw) begin errors++; $display("FAIL %s readback got %h exp %h", tag, cpu_rdata, expw); end
        to_drive();
        idle_inputs();
    endtask

    task automatic test_byte_store();
        // word 5 = 0x00000085, byte 1 (bits 23:16) <- 0x55
        sub_store("sb", 2'b00, 6'h15, 32'h1234_5655, 32'h0055_0085);
        exp_mem[5] = 32'h0055_0085;
    endtask

    task automatic test_half_store();
        // word 6 = 0x00000086, half 1 (bits 15:0) <- 0xA5A5
        sub_store("sh", 2'b01, 6'h1A, 32'hFFFF_A5A5, 32'h0000_A5A5);
        exp_mem[6] = 32'h0000_A5A5;
    endtask

    task automatic test_dump_stress();
        // SB 0x77 to byte 0 of word 15 lands long before word 15 is captured.
        exp_mem[15] = 32'h7700_008F;
        run_dump("dump_stress", 4, 7, 1'b1);
        cpu_re = 1'b1; cpu_size = 2'b11; cpu_addr = 6'h3C;
        to_check();
        checks++; if (cpu_rdata !== 32'h7700_008F) begin errors++; $display("FAIL stress_sb_readback got %h exp 7700008f", cpu_rdata); end
        to_drive();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        int extra_done = 0;
        int extra_valid = 0;
        dbg_ready = 1'b0; dbg_start = 1'b1;
        to_check(); to_drive();
        dbg_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            to_check();
            if (dbg_valid) begin seen = 1'b1; break; end
            to_drive();
        end
        checks++; if (!seen) begin errors++; $display("FAIL rst_dump_wait timeout got valid=0 exp 1"); end
        to_drive();
        reset = 1'b1;
        to_check(); to_drive();
        reset = 1'b0; dbg_ready = 1'b1;
        to_check();
        checks++;
        if (dbg_valid !== 1'b0 || dbg_done !== 1'b0 || dbg_data !== 32'h0 || dbg_addr !== 4'h0 ||
            cpu_stall !== 1'b0 || ram_en !== 1'b0 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL rst_dump outputs got v=%b d=%b data=%h a=%0d st=%b en=%b we=%b exp all 0",
                     dbg_valid, dbg_done, dbg_data, dbg_addr, cpu_stall, ram_en, ram_we);
        end
        for (int k = 0; k < 5; k++) begin
            if (dbg_done) extra_done++;
            if (dbg_valid) extra_valid++;
            to_drive(); to_check();
        end
        checks++; if (extra_done !== 0 || extra_valid !== 0) begin errors++; $display("FAIL rst_dump_abort got done=%0d valid=%0d exp 0 0", extra_done, extra_valid); end
        to_drive();
        // reset during the merged-write cycle of SB 0x99 to word 8
        cpu_we = 1'b1; cpu_size = 2'b00; cpu_addr = 6'h20; cpu_wdata = 32'h0000_0099;
        to_check();
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL rst_rmw_stall got %b exp 1", cpu_stall); end
        to_drive();
        idle_inputs(); reset = 1'b1;
        to_check();
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_rmw_we got %b exp 0", ram_we); end
        to_drive();
        reset = 1'b0;
        to_check();
        checks++;
        if (cpu_stall !== 1'b0 || ram_en !== 1'b0 || ram_we !== 1'b0 || dbg_valid !== 1'b0 || dbg_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_rmw outputs got st=%b en=%b we=%b v=%b d=%b exp all 0", cpu_stall, ram_en, ram_we, dbg_valid, dbg_done);
        end
        to_drive();
        cpu_re = 1'b1; cpu_size = 2'b11; cpu_addr = 6'h20;
        to_check();
        checks++; if (cpu_rdata !== 32'h0000_0088) begin errors++; $display("FAIL rst_rmw_word got %h exp 00000088", cpu_rdata); end
        to_drive();
        idle_inputs();
    endtask

    initial begin
        checks = 0; errors = 0;
        ram_dout = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 32'(i) + 32'h80;
            exp_mem[i] = 32'(i) + 32'h80;
        end
        reset = 1'b1; dbg_ready = 1'b0; idle_inputs();
        test_reset();
        test_load();
        test_dump_basic();
        test_word_store();
        test_byte_store();
        test_half_store();
        test_dump_stress();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
